onehot_scan_decoder: RTL and testbench

Parametrised registered one-hot decoder: SEL_W select bits drive 2^SEL_W path outputs, one bit active at a time.
Beyond direct decode, it adds:
- free-running scan mode with programmable dwell per output;
- single-sweep mode with start/busy/done handshake;
- blank mode.
It is the next-generation selector for LED/digit multiplexing and channel sequencing, and replaces fixed 4-to-16 decode trees.

---
 rtl/onehot_scan_decoder_pkg.sv | 14 +
 rtl/onehot_scan_decoder_dec.sv | 11 +
 rtl/onehot_scan_decoder.sv | 119 +++++++++++
 tb/tb_onehot_scan_decoder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/onehot_scan_decoder_pkg.sv
// onehot_scan_decoder_pkg: mode and FSM state encodings shared by the decoder files.
package onehot_scan_decoder_pkg;
    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;
    localparam logic [1:0] MODE_BLANK  = 2'b11;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIRECT = 3'd1,
        ST_SCAN   = 3'd2,
        ST_SWEEP  = 3'd3,
        ST_BLANK  = 3'd4
    } state_e;
endpackage

// File: rtl/onehot_scan_decoder_dec.sv
// onehot_dec: combinational SEL_W-to-2**SEL_W one-hot decoder.
module onehot_dec #(
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]      sel_i,
    output logic [2**SEL_W-1:0]   dec_o
);
    for (genvar i = 0; i < 2**SEL_W; i++) begin : g_bit
        assign dec_o[i] = (sel_i == SEL_W'(i));
    end
endmodule

// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered one-hot selector with direct, scan, sweep and blank modes.
module onehot_scan_decoder
    import onehot_scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      select,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  start,
    output logic [2**SEL_W-1:0]   path,
    output logic [SEL_W-1:0]      index,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
);
    localparam int OUT_W = 2**SEL_W;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d, dwl_q, dwl_d;
    logic [OUT_W-1:0]   path_q, path_d, dec_w;
    logic               busy_q, busy_d, done_q, done_d, wrap_q, wrap_d, on_d;
    logic               step, last;

    assign step = (cnt_q == dwl_q);
    assign last = step && (&idx_q);

    onehot_dec #(.SEL_W(SEL_W)) u_dec (.sel_i(idx_d), .dec_o(dec_w));

    // dwl_q latches dwell at each step boundary so mid-step changes wait for the next step
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dwl_d   = dwl_q;
        busy_d  = busy_q;
        on_d    = |path_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        if (en) begin
            busy_d = 1'b0;
            on_d   = 1'b1;
            cnt_d  = '0;
            case (mode)
                MODE_DIRECT: begin
                    state_d = ST_DIRECT;
                    idx_d   = select;
                end
                MODE_SCAN: begin
                    if (state_q != ST_SCAN) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                        dwl_d   = dwell;
                    end else begin
                        cnt_d  = step ? '0 : cnt_q + 1'b1;
                        idx_d  = step ? idx_q + 1'b1 : idx_q;
                        dwl_d  = step ? dwell : dwl_q;
                        wrap_d = last;
                    end
                end
                MODE_SWEEP: begin
                    if (state_q == ST_SWEEP) begin
                        state_d = last ? ST_IDLE : ST_SWEEP;
                        busy_d  = !last;
                        done_d  = last;
                        on_d    = !last;
                        cnt_d   = step ? '0 : cnt_q + 1'b1;
                        idx_d   = step ? idx_q + 1'b1 : idx_q;
                        dwl_d   = step ? dwell : dwl_q;
                    end else begin
                        state_d = start ? ST_SWEEP : ST_IDLE;
                        busy_d  = start;
                        on_d    = start;
                        idx_d   = start ? '0 : idx_q;
                        dwl_d   = dwell;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    on_d    = 1'b0;
                end
            endcase
        end
        path_d = on_d ? dec_w : '0;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            dwl_q   <= '0;
            path_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dwl_q   <= dwl_d;
            path_q  <= path_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign path  = path_q;
    assign index = idx_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign wrap  = wrap_q;
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb_onehot_scan_decoder: scoreboard bench for the 16-way and 8-way decoder instances.
module tb_onehot_scan_decoder;
    typedef logic [22:0] exp_t;

    logic        clk1 = 1'b0;
    logic        rst, en, start;
    logic [1:0]  mode;
    logic [3:0]  select;
    logic [7:0]  dwell;
    logic [15:0] path;
    logic [3:0]  index;
    logic        busy, done, wrap;

    logic        b_rst, b_en, b_start, b_fin;
    logic [1:0]  b_mode;
    logic [2:0]  b_select;
    logic [7:0]  b_dwell;
    logic [7:0]  b_path;
    logic [2:0]  b_index;
    logic        b_busy, b_done, b_wrap;

    exp_t  qa[$], qb[$];
    string na[$], nb[$];
    exp_t  e;
    exp_t  got;
    string nm;
    int    checks = 0;
    int    errors = 0;

    always #5 clk1 = ~clk1;

    onehot_scan_decoder #(.SEL_W(4), .DWELL_W(8)) dut (
        .clk1(clk1), .rst(rst), .en(en), .mode(mode), .select(select), .dwell(dwell),
        .start(start), .path(path), .index(index), .busy(busy), .done(done), .wrap(wrap)
    );

    onehot_scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut3 (
        .clk1(clk1), .rst(b_rst), .en(b_en), .mode(b_mode), .select(b_select), .dwell(b_dwell),
        .start(b_start), .path(b_path), .index(b_index), .busy(b_busy), .done(b_done), .wrap(b_wrap)
    );

    task automatic step(input logic [15:0] p, input logic [3:0] ix, input logic b, input logic d,
                        input logic w, input string n);
        qa.push_back({p, ix, b, d, w});
        na.push_back(n);
        @(negedge clk1);
    endtask

    task automatic bstep(input logic [15:0] p, input logic [3:0] ix, input logic w, input string n);
        qb.push_back({p, ix, 1'b0, 1'b0, w});
        nb.push_back(n);
        @(negedge clk1);
    endtask

    // one expectation per clock per instance, sampled 1ns after the rising edge
    always begin
        @(posedge clk1);
        #1;
        if (qa.size() != 0) begin
            e   = qa.pop_front();
            nm  = na.pop_front();
            got = {path, index, busy, done, wrap};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s @%0t: got path=%h idx=%0d busy=%b done=%b wrap=%b, want path=%h idx=%0d busy=%b done=%b wrap=%b",
                         nm, $time, got[22:7], got[6:3], got[2], got[1], got[0], e[22:7], e[6:3], e[2], e[1], e[0]);
            end
        end
        if (qb.size() != 0) begin
            e   = qb.pop_front();
            nm  = nb.pop_front();
            got = {8'h00, b_path, 1'b0, b_index, b_busy, b_done, b_wrap};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s @%0t: got path=%h idx=%0d busy=%b done=%b wrap=%b, want path=%h idx=%0d busy=%b done=%b wrap=%b",
                         nm, $time, got[22:7], got[6:3], got[2], got[1], got[0], e[22:7], e[6:3], e[2], e[1], e[0]);
            end
        end
        checks++;
        if (!$onehot0(path) || (path != 16'h0 && !path[index])) begin
            errors++;
            $display("FAIL onehot16 @%0t: got path=%h idx=%0d, want zero or one-hot with path[idx]=1", $time, path, index);
        end
        checks++;
        if (!$onehot0(b_path) || (b_path != 8'h0 && !b_path[b_index])) begin
            errors++;
            $display("FAIL onehot8 @%0t: got path=%h idx=%0d, want zero or one-hot with path[idx]=1", $time, b_path, b_index);
        end
    end

    initial begin
        b_fin = 1'b0; b_rst = 1'b1; b_en = 1'b1; b_mode = 2'b01; b_select = '0; b_dwell = 8'd0; b_start = 1'b0;
        bstep(16'h0, 4'd0, 1'b0, "b_reset");
        b_rst = 1'b0;
        for (int c = 0; c < 20; c++)
            bstep(16'(1) << (c % 8), 4'(c % 8), (c == 8 || c == 16), "b_scan");
        b_fin = 1'b1;
    end

    initial begin
        rst = 1'b1; en = 1'b1; mode = 2'b01; select = 4'h0; dwell = 8'd0; start = 1'b0;
        step(16'h0, 4'd0, 1'b0, 1'b0, 1'b0, "reset");
        step(16'h0, 4'd0, 1'b0, 1'b0, 1'b0, "reset2");
        rst = 1'b0;
        for (int c = 0; c < 18; c++)
            step(16'(1) << (c % 16), 4'(c % 16), 1'b0, 1'b0, (c == 16), "scan_d0");
        mode = 2'b00; select = 4'hA;
        step(16'h0400, 4'd10, 1'b0, 1'b0, 1'b0, "direct_a");
        en = 1'b0; select = 4'h3;
        step(16'h0400, 4'd10, 1'b0, 1'b0, 1'b0, "en_hold");
        step(16'h0400, 4'd10, 1'b0, 1'b0, 1'b0, "en_hold2");
        en = 1'b1;
        step(16'h0008, 4'd3, 1'b0, 1'b0, 1'b0, "direct_3");
        mode = 2'b01; dwell = 8'd2;
        for (int c = 0; c < 51; c++)
            step(16'(1) << ((c / 3) % 16), 4'((c / 3) % 16), 1'b0, 1'b0, (c == 48), "scan_d2");
        mode = 2'b10; dwell = 8'd1;
        step(16'h0, 4'd0, 1'b0, 1'b0, 1'b0, "sweep_idle");
        for (int c = 0; c < 32; c++) begin
            start = (c == 0 || c == 5);
            step(16'(1) << (c / 2), 4'(c / 2), 1'b1, 1'b0, 1'b0, "sweep_d1");
        end
        start = 1'b0;
        step(16'h0, 4'd0, 1'b0, 1'b1, 1'b0, "sweep_done");
        step(16'h0, 4'd0, 1'b0, 1'b0, 1'b0, "sweep_after");
        start = 1'b1; dwell = 8'd0;
        for (int c = 0; c < 16; c++)
            step(16'(1) << c, 4'(c), 1'b1, 1'b0, 1'b0, "sweep_hold");
        step(16'h0, 4'd0, 1'b0, 1'b1, 1'b0, "hold_done");
        step(16'h0001, 4'd0, 1'b1, 1'b0, 1'b0, "relaunch");
        start = 1'b0;
        for (int c = 1; c < 6; c++)
            step(16'(1) << c, 4'(c), 1'b1, 1'b0, 1'b0, "resweep");
        mode = 2'b11;
        step(16'h0, 4'd5, 1'b0, 1'b0, 1'b0, "abort");
        step(16'h0, 4'd5, 1'b0, 1'b0, 1'b0, "blank_hold");
        step(16'h0, 4'd5, 1'b0, 1'b0, 1'b0, "blank_hold2");
        mode = 2'b00; select = 4'hF;
        step(16'h8000, 4'd15, 1'b0, 1'b0, 1'b0, "direct_f");
        for (int k = 0; k < 200 && !(b_fin && qa.size() == 0 && qb.size() == 0); k++)
            @(negedge clk1);
        @(negedge clk1);
        checks++;
        if (!b_fin || qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got pending=%0d/%0d fin=%b, want 0/0 fin=1", qa.size(), qb.size(), b_fin);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
